// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC virtual-channel input port:
//   - default flit width, per-VC depth and VC count
//   - vc_idx_t / flit_t typedefs sized from those defaults
//   - vc_width(): index width for a given VC count (never below 1 bit)
// -----------------------------------------------------------------------------
package noc_pkg;

   localparam int NOC_DATA_W = 16;
   localparam int NOC_DEPTH  = 5;
   localparam int NOC_NUM_VC = 2;

   function automatic int vc_width(input int num_vc);
      return (num_vc > 1) ? $clog2(num_vc) : 1;
   endfunction

   localparam int NOC_VCW = vc_width(NOC_NUM_VC);

   typedef logic [NOC_VCW-1:0]    vc_idx_t;
   typedef logic [NOC_DATA_W-1:0] flit_t;

endpackage

// File: rtl/noc_vc_fifo.sv
// -----------------------------------------------------------------------------
// noc_vc_fifo
// Single virtual-channel circular FIFO with show-ahead read.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointers/count only)
//   push        : store data_i at the write pointer (caller guarantees room,
//                 or a simultaneous pop when full)
//   pop         : advance the read pointer (caller guarantees non-empty)
//   data_i      : flit to store
//   data_o      : flit at the read pointer (combinational)
//   empty, full : decoded from the registered occupancy count
// -----------------------------------------------------------------------------
module noc_vc_fifo
   import noc_pkg::*;
#(
   parameter int DATA_W = NOC_DATA_W,
   parameter int DEPTH  = NOC_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              empty,
   output logic              full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   // DEPTH need not be a power of two, so wrap explicitly at DEPTH-1.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   assign data_o = mem[rd_ptr];
   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));

endmodule

// File: rtl/noc_vc_input_port.sv
// -----------------------------------------------------------------------------
// noc_vc_input_port
// NoC router input port with NUM_VC independent virtual-channel FIFOs,
// credit return on every pop and sticky overflow/underflow error flags.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   data_i, vc_i : incoming flit and its target VC
//   write_en     : push request
//   shift        : pop request for VC shift_vc
//   data_o       : head flit of VC shift_vc (show-ahead, undefined when empty)
//   read_valid_o : per-VC non-empty
//   full_o       : per-VC full
//   credit_o     : one-cycle pulse the cycle after a successful pop
//   credit_vc_o  : VC of that pop
//   overflow_o   : sticky, write dropped (full VC or VC index out of range)
//   underflow_o  : sticky, pop ignored (empty VC or VC index out of range)
// -----------------------------------------------------------------------------
module noc_vc_input_port
   import noc_pkg::*;
#(
   parameter  int DATA_W = NOC_DATA_W,
   parameter  int DEPTH  = NOC_DEPTH,
   parameter  int NUM_VC = NOC_NUM_VC,
   localparam int VCW    = vc_width(NUM_VC)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_i,
   input  logic [VCW-1:0]    vc_i,
   input  logic              write_en,
   input  logic              shift,
   input  logic [VCW-1:0]    shift_vc,
   output logic [DATA_W-1:0] data_o,
   output logic [NUM_VC-1:0] read_valid_o,
   output logic [NUM_VC-1:0] full_o,
   output logic              credit_o,
   output logic [VCW-1:0]    credit_vc_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   logic [NUM_VC-1:0] push_v;
   logic [NUM_VC-1:0] pop_v;
   logic [NUM_VC-1:0] empty_v;
   logic [NUM_VC-1:0] full_v;
   logic [DATA_W-1:0] head_v [NUM_VC];

   // Widen before comparing so the check stays meaningful when NUM_VC is
   // not a power of two (and quiet when it is).
   logic wr_in_range;
   logic rd_in_range;
   assign wr_in_range = (32'(vc_i)     < 32'(NUM_VC));
   assign rd_in_range = (32'(shift_vc) < 32'(NUM_VC));

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      // Pop only from a non-empty VC; a push into a full VC is allowed
      // only when that same VC frees a slot this cycle.  An empty VC
      // with push+pop therefore sees only the push (no bypass).
      assign pop_v[v]  = shift && rd_in_range && (shift_vc == VCW'(v)) && !empty_v[v];
      assign push_v[v] = write_en && wr_in_range && (vc_i == VCW'(v))
                         && (!full_v[v] || pop_v[v]);

      noc_vc_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk    (clk),
         .rst_n  (rst_n),
         .push   (push_v[v]),
         .pop    (pop_v[v]),
         .data_i (data_i),
         .data_o (head_v[v]),
         .empty  (empty_v[v]),
         .full   (full_v[v])
      );
   end

   always_comb begin
      data_o = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (shift_vc == VCW'(v)) begin
            data_o = head_v[v];
         end
      end
   end

   assign read_valid_o = ~empty_v;
   assign full_o       = full_v;

   logic write_drop;
   logic shift_drop;
   assign write_drop = write_en && (push_v == '0);
   assign shift_drop = shift    && (pop_v  == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_o    <= 1'b0;
         credit_vc_o <= '0;
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         credit_o <= |pop_v;
         if (|pop_v) begin
            credit_vc_o <= shift_vc;
         end
         if (write_drop) begin
            overflow_o <= 1'b1;
         end
         if (shift_drop) begin
            underflow_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_noc_vc_input_port.sv
// -----------------------------------------------------------------------------
// tb_noc_vc_input_port
// Scoreboard bench for noc_vc_input_port with default parameters.
// -----------------------------------------------------------------------------
module tb_noc_vc_input_port;

   localparam int DW    = 16;
   localparam int DEPTH = 5;
   localparam int NVC   = 2;
   localparam int VCW   = 1;

   logic           clk;
   logic           rst_n;
   logic [DW-1:0]  data_i;
   logic [VCW-1:0] vc_i;
   logic           write_en;
   logic           shift;
   logic [VCW-1:0] shift_vc;
   logic [DW-1:0]  data_o;
   logic [NVC-1:0] read_valid_o;
   logic [NVC-1:0] full_o;
   logic           credit_o;
   logic [VCW-1:0] credit_vc_o;
   logic           overflow_o;
   logic           underflow_o;

   noc_vc_input_port #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .NUM_VC (NVC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_i       (data_i),
      .vc_i         (vc_i),
      .write_en     (write_en),
      .shift        (shift),
      .shift_vc     (shift_vc),
      .data_o       (data_o),
      .read_valid_o (read_valid_o),
      .full_o       (full_o),
      .credit_o     (credit_o),
      .credit_vc_o  (credit_vc_o),
      .overflow_o   (overflow_o),
      .underflow_o  (underflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Scoreboard: expected flits per VC plus expected flag state.
   logic [DW-1:0]  sb_q [NVC][$];
   logic           exp_ovf;
   logic           exp_udf;
   logic           exp_cred;
   logic [VCW-1:0] exp_cvc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [NVC-1:0] exp_valid();
      logic [NVC-1:0] r;
      for (int v = 0; v < NVC; v++) r[v] = (sb_q[v].size() > 0);
      return r;
   endfunction

   function automatic logic [NVC-1:0] exp_full();
      logic [NVC-1:0] r;
      for (int v = 0; v < NVC; v++) r[v] = (sb_q[v].size() == DEPTH);
      return r;
   endfunction

   task automatic check_regs(input string tag);
      check({tag, ".read_valid"}, 32'(read_valid_o), 32'(exp_valid()));
      check({tag, ".full"},       32'(full_o),       32'(exp_full()));
      check({tag, ".credit"},     32'(credit_o),     32'(exp_cred));
      if (exp_cred) check({tag, ".credit_vc"}, 32'(credit_vc_o), 32'(exp_cvc));
      check({tag, ".overflow"},   32'(overflow_o),   32'(exp_ovf));
      check({tag, ".underflow"},  32'(underflow_o),  32'(exp_udf));
   endtask

   // Called just after a falling edge: drive, check show-ahead data, update
   // the scoreboard, clock once, then check registered state.
   task automatic step(input string tag, input logic we, input logic [VCW-1:0] vci,
                       input logic [DW-1:0] din, input logic sh, input logic [VCW-1:0] svc);
      logic          pop_ok;
      logic          push_ok;
      logic [DW-1:0] popped;
      write_en = we;
      vc_i     = vci;
      data_i   = din;
      shift    = sh;
      shift_vc = svc;
      #1;
      pop_ok = sh && (sb_q[svc].size() > 0);
      if (pop_ok) begin
         popped = sb_q[svc].pop_front();
         check({tag, ".pop_data"}, 32'(data_o), 32'(popped));
      end
      push_ok = we && ((sb_q[vci].size() < DEPTH) || (pop_ok && (svc == vci)));
      if (push_ok) sb_q[vci].push_back(din);
      if (we && !push_ok) exp_ovf = 1'b1;
      if (sh && !pop_ok)  exp_udf = 1'b1;
      exp_cred = pop_ok;
      if (pop_ok) exp_cvc = svc;
      @(posedge clk);
      @(negedge clk);
      write_en = 1'b0;
      shift    = 1'b0;
      #1;
      check_regs(tag);
      if (sb_q[svc].size() > 0) check({tag, ".head"}, 32'(data_o), 32'(sb_q[svc][0]));
   endtask

   task automatic clear_model();
      for (int v = 0; v < NVC; v++) sb_q[v].delete();
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
      exp_cred = 1'b0;
      exp_cvc  = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      data_i   = '0;
      vc_i     = '0;
      write_en = 1'b0;
      shift    = 1'b0;
      shift_vc = '0;
      clear_model();

      repeat (2) @(negedge clk);
      #1;
      check_regs("reset");
      check("reset.credit_vc", 32'(credit_vc_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill VC0, then overflow it.
      for (int i = 1; i <= 5; i++) step("fill", 1'b1, 1'b0, DW'(i), 1'b0, 1'b0);
      check("fill.full_o", 32'(full_o), 32'h1);
      step("overflow", 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0);
      check("overflow.flag", 32'(overflow_o), 32'h1);

      // Push+pop on a full VC: count stays at DEPTH, head moves to 0x0002.
      step("full_pushpop", 1'b1, 1'b0, 16'h00AA, 1'b1, 1'b0);
      check("full_pushpop.head", 32'(data_o), 32'h0002);
      check("full_pushpop.credit", 32'(credit_o), 32'h1);

      // Push VC1 while popping VC0.
      step("cross", 1'b1, 1'b1, 16'h0100, 1'b1, 1'b0);
      check("cross.valid", 32'(read_valid_o), 32'h3);

      // Drain VC0 (0x0003, 0x0004, 0x0005, 0x00AA).
      for (int i = 0; i < 4; i++) step("drain0", 1'b0, 1'b0, '0, 1'b1, 1'b0);

      // Drain VC1, then pop it while empty.
      step("drain1", 1'b0, 1'b0, '0, 1'b1, 1'b1);
      step("udf", 1'b0, 1'b0, '0, 1'b1, 1'b1);
      check("udf.flag", 32'(underflow_o), 32'h1);
      check("udf.no_credit", 32'(credit_o), 32'h0);

      // Empty VC with push+pop: only the push happens.
      step("empty_pushpop", 1'b1, 1'b0, 16'h0C00, 1'b1, 1'b0);
      step("empty_pushpop_drain", 1'b0, 1'b0, '0, 1'b1, 1'b0);

      // 12 push/pop pairs on VC0, walking both pointers round several times.
      for (int i = 0; i < 12; i++)
         step("wrap", 1'b1, 1'b0, DW'(16'h1000 + i), (i != 0), 1'b0);
      step("wrap_drain", 1'b0, 1'b0, '0, 1'b1, 1'b0);

      // Random mixed traffic on both VCs.
      for (int i = 0; i < 60; i++)
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Reset mid-stream with three flits buffered in VC1.
      @(posedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      for (int i = 0; i < 3; i++) step("prefill", 1'b1, 1'b1, DW'(16'h0B00 + i), 1'b0, 1'b0);
      step("poke_udf", 1'b0, 1'b0, '0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      clear_model();
      check("midreset.valid",     32'(read_valid_o), 32'h0);
      check("midreset.full",      32'(full_o),       32'h0);
      check("midreset.overflow",  32'(overflow_o),   32'h0);
      check("midreset.underflow", 32'(underflow_o),  32'h0);
      check("midreset.credit",    32'(credit_o),     32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step("post_reset_push", 1'b1, 1'b0, 16'h0BEE, 1'b0, 1'b0);
      check("post_reset.valid", 32'(read_valid_o), 32'h1);
      step("post_reset_pop", 1'b0, 1'b0, '0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noc_vc_input_port.md
NOC_VC_INPUT_PORT -- requirements
Module: noc_vc_input_port

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning flit width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 5, meaning flits per virtual channel (VC), any value >= 2, not restricted to powers of 2.
REQ-003 The block SHALL have parameter NUM_VC, default 2, meaning number of VCs, >= 1.
REQ-004 The block SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-005 The block SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have ports: data_i  in  DATA_W  incoming flit.
REQ-007 The block SHALL have ports: vc_i  in  VCW  target VC of incoming flit, VCW = max(1, clog2(NUM_VC)).
REQ-008 The block SHALL have ports: write_en  in  1  push request.
REQ-009 The block SHALL have ports: shift  in  1  pop request.
REQ-010 The block SHALL have ports: shift_vc  in  VCW  VC to read and pop.
REQ-011 The block SHALL have ports: data_o  out  DATA_W  head flit of VC shift_vc.
REQ-012 The block SHALL have ports: read_valid_o  out  NUM_VC  bit v high when VC v is non-empty.
REQ-013 The block SHALL have ports: full_o  out  NUM_VC  bit v high when VC v holds DEPTH flits.
REQ-014 The block SHALL have ports: credit_o  out  1  one-cycle credit-return pulse.
REQ-015 The block SHALL have ports: credit_vc_o  out  VCW  VC of the returned credit.
REQ-016 The block SHALL have ports: overflow_o, underflow_o  out  1 each  sticky error flags.

Function
REQ-017 Each VC SHALL be an independent circular FIFO with read and write pointers that wrap from DEPTH-1 to 0, and an occupancy counter ranging 0..DEPTH.
REQ-018 A push SHALL occur on a clock edge when write_en=1 and VC vc_i is not full (or is full and is popped in the same cycle); data_i SHALL then be stored at the write pointer.
REQ-019 When write_en=1 to a full VC with no same-cycle pop, the flit SHALL be dropped, no state SHALL change, and overflow_o SHALL be set.
REQ-020 A pop SHALL occur when shift=1 and VC shift_vc is non-empty; when shift=1 and the VC is empty, no pop SHALL occur and underflow_o SHALL be set.
REQ-021 data_o SHALL be combinational show-ahead (the head of VC shift_vc, zero latency); data_o is undefined when that VC is empty.
REQ-022 A push and a pop to the same VC in one cycle SHALL leave its count unchanged; if the VC is empty, only the push SHALL take effect (no bypass).
REQ-023 Simultaneous push to VC a and pop from VC b (a != b) SHALL both complete independently.
REQ-024 read_valid_o and full_o SHALL be derived from the registered counts (no combinational path from inputs).
REQ-025 credit_o SHALL be 1 exactly in the cycle after each successful pop, with credit_vc_o equal to that pop's shift_vc; otherwise credit_o SHALL be 0.
REQ-026 A vc_i or shift_vc value >= NUM_VC SHALL be treated as an error: the write SHALL be dropped with overflow_o set, or the pop ignored with underflow_o set.
REQ-027 overflow_o and underflow_o SHALL clear only on reset.

Reset
REQ-028 While rst_n=0, all pointers, counts, credit_o, credit_vc_o, overflow_o and underflow_o SHALL be 0; read_valid_o SHALL be 0 and full_o SHALL be 0. Storage contents are not reset.
REQ-029 Reset asserted mid-operation SHALL discard all buffered flits immediately; the first edge after deassertion SHALL accept a push normally.

Structure
REQ-030 Package noc_pkg SHALL hold the default DATA_W, DEPTH and NUM_VC localparams, the vc_idx_t typedef, and the flit_t typedef.
REQ-031 The per-VC FIFO SHALL be a sub-module noc_vc_fifo (DATA_W, DEPTH), instantiated NUM_VC times via generate.

Verification
REQ-032 Scenario: with defaults, push 5 flits 0x0001..0x0005 to VC0 -> full_o=2'b01; a 6th push sets overflow_o=1; pops return 1..5 in order.
REQ-033 Scenario: with VC0 full, push 0x00AA and pop VC0 in the same cycle -> count stays 5, data_o=0x0002, credit_o=1 next cycle with credit_vc_o=0.
REQ-034 Scenario: push to VC1 while popping VC0 -> both complete; read_valid_o reflects per-VC occupancy.
REQ-035 Scenario: pop empty VC1 -> underflow_o=1, no credit_o pulse, counts unchanged.
REQ-036 Scenario: perform 12 push/pop pairs on VC0 with DEPTH=5 -> pointer wrap is correct and data order is preserved.
REQ-037 Scenario: assert rst_n=0 mid-stream with 3 flits buffered -> read_valid_o=0 and flags cleared immediately; a push on the next edge after release is accepted.
